approx_err_stats: RTL
=====================

Name: approx_err_stats

Overview:
- Downstream consumer of the approximate ripple-carry adders (nBitRcpa1/2/3).
- Takes each operand pair A/B and the adder's approximate result {fn, sum}.
- Computes the exact (N+1)-bit sum internally and accumulates error metrics over a programmed run of samples: error count, summed error distance, maximum error distance and over-estimate count.
- One instance sits behind each adder under characterisation; results feed ER/MED reporting.

Parameters:
- N, 8, operand and sum width of the adder under test.
- CNT_W, 16, width of the sample and error counters.
- SAMPLES, 256, samples per run; legal range 1 .. 2^CNT_W-1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  single-cycle pulse; clears accumulators and begins a run.
- in_valid  input  1  sample on a/b/sum/fn is valid.
- in_ready  output  1  block accepts a sample this cycle.
- a  input  N  operand A given to the adder.
- b  input  N  operand B given to the adder.
- sum  input  N  approximate sum from the adder.
- fn  input  1  approximate carry-out from the adder.
- busy  output  1  run in progress.
- done  output  1  run complete; results stable.
- sample_cnt  output  CNT_W  samples accepted in the current or last run.
- err_cnt  output  CNT_W  samples with nonzero error distance.
- over_cnt  output  CNT_W  samples where approx > exact.
- ed_sum  output  N+1+CNT_W  sum of error distances.
- ed_max  output  N+1  largest single error distance.

Behaviour:
- Reset: when rst_n=0 at a clk edge, the FSM goes to IDLE and every output is 0, including in_ready, busy and done.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on start.
  - RUN -> DONE on the edge that accepts the SAMPLES-th sample.
  - DONE -> RUN on start.
  - start while in RUN clears all accumulators and restarts the run; the state stays RUN.
- Register updates when start is seen: sample_cnt, err_cnt, over_cnt, ed_sum and ed_max clear to 0 on the same edge. A sample presented in that cycle is not accepted.
- Combinational outputs: in_ready = busy = (state==RUN); done = (state==DONE).
- Handshake: a sample is accepted on an edge where in_valid && in_ready. When in_valid=0 nothing updates. There is no back-pressure other than in_ready.
- Arithmetic, all unsigned and evaluated on the accept cycle:
  - exact = a + b, in N+1 bits.
  - approx = {fn, sum}.
  - ed = |exact - approx|, in N+1 bits.
- Updates on an accepted sample:
  - sample_cnt += 1.
  - err_cnt += (ed != 0).
  - over_cnt += (approx > exact).
  - ed_sum += ed.
  - ed_max = max(ed_max, ed).
- Latency: the updated metrics are visible the cycle after acceptance. done rises in the same cycle as the final sample_cnt = SAMPLES.
- No wrap: the ed_sum width guarantees no overflow. Counters never exceed SAMPLES.
- DONE state: outputs hold indefinitely and in_valid is ignored. Only start or reset changes them.
- Reset mid-run: the partial results are discarded and all outputs return to 0 on the next edge.
- SAMPLES=1: the first accepted sample moves the FSM straight to DONE.

Test Plan:
- Reset hold then release, no start → all outputs 0, in_ready=0. in_valid=1 with a=0x32, b=0x01 → sample_cnt stays 0.
- SAMPLES=4, start, then four exact samples: (0x32,0x01,sum=0x33,fn=0), (0x51,0x12,0x63,0), (0x3C,0x51,0x8D,0), (0x67,0x61,0xC8,0) → sample_cnt=4, err_cnt=0, over_cnt=0, ed_sum=0, ed_max=0, done=1 one cycle after the 4th accept.
- SAMPLES=4, erroneous samples:
  - a=0x4B, b=0x15, sum=0x5E, fn=0 (exact 0x60, ed=2).
  - a=0x0B, b=0x17, sum=0x26, fn=0 (exact 0x22, ed=4, over).
  - a=0x7D, b=0x21, sum=0x9E, fn=0 (ed=0).
  - a=0xFF, b=0x01, sum=0x00, fn=0 (exact 0x100, ed=256).
  - Required: err_cnt=3, over_cnt=1, ed_sum=262, ed_max=256.
- in_valid toggled 1,0,0,1,1,0,1 during a SAMPLES=4 run → only valid cycles counted; done after the 4th valid. Further in_valid in DONE leaves all metrics unchanged.
- start pulsed mid-run after 2 erroneous samples → metrics cleared to 0 on that edge and busy stays 1. A new run of 4 samples completes normally.
- rst_n driven 0 for one cycle mid-run with ed_sum=6 → next cycle all outputs 0 and state IDLE. A following start runs cleanly.

Source files
------------

// File: rtl/approx_err_stats.sv
// approx_err_stats: accumulates error metrics of an approximate adder over a run of samples
module approx_err_stats #(
    parameter int N       = 8,
    parameter int CNT_W   = 16,
    parameter int SAMPLES = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         a,
    input  logic [N-1:0]         b,
    input  logic [N-1:0]         sum,
    input  logic                 fn,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     sample_cnt,
    output logic [CNT_W-1:0]     err_cnt,
    output logic [CNT_W-1:0]     over_cnt,
    output logic [N+CNT_W:0]     ed_sum,
    output logic [N:0]           ed_max
);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2;
    logic [1:0] state;
    logic [N:0] exact, approx, ed;
    logic       over, accept;
    always_comb begin
        exact  = {1'b0, a} + {1'b0, b};
        approx = {fn, sum};
        over   = approx > exact;
        ed     = over ? approx - exact : exact - approx;
        accept = in_valid && state == RUN && !start;
    end
    assign in_ready = state == RUN;
    assign busy     = state == RUN;
    assign done     = state == FIN;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            sample_cnt <= '0;
            err_cnt    <= '0;
            over_cnt   <= '0;
            ed_sum     <= '0;
            ed_max     <= '0;
        end else if (start) begin
            state      <= RUN;
            sample_cnt <= '0;
            err_cnt    <= '0;
            over_cnt   <= '0;
            ed_sum     <= '0;
            ed_max     <= '0;
        end else if (accept) begin
            sample_cnt <= sample_cnt + 1'b1;
            err_cnt    <= err_cnt + {{(CNT_W-1){1'b0}}, ed != '0};
            over_cnt   <= over_cnt + {{(CNT_W-1){1'b0}}, over};
            ed_sum     <= ed_sum + {{CNT_W{1'b0}}, ed};
            ed_max     <= ed > ed_max ? ed : ed_max;
            if (sample_cnt == CNT_W'(SAMPLES - 1)) state <= FIN;
        end
    end
endmodule
